mem_access_stage: RTL
=====================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have these ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low
- reg_data  in  32  ALU result / pass-through data from MEM pipeline register
- mem_data  in  32  store data
- mem_address  in  32  byte address
- load, store, write_reg, enable  in  1 each  control from MEM pipeline register
- reg_address  in  5  destination register
- stall  out  1  freeze upstream pipeline registers
- dmem_req  out  1  bus request
- dmem_we  out  1  bus write enable
- dmem_addr  out  32  bus word address
- dmem_wdata  out  32  bus write data
- dmem_ack  in  1  bus acknowledge
- dmem_rdata  in  32  bus read data
- wb_data  out  32  write-back data
- wb_reg_address  out  5  write-back destination
- wb_write_reg  out  1  write-back register-write strobe
- wb_enable  out  1  write-back valid
- wb_error  out  1  access fault flag for the retiring instruction
REQ-002 SHALL have one parameter: TIMEOUT, default 255, meaning the maximum number of ACCESS cycles spent waiting for dmem_ack.

Function
REQ-003 SHALL decode mem_op = enable & (load | store).
REQ-004 SHALL decode fault = mem_op & ((mem_address[1:0] != 0) | (load & store)).
REQ-005 SHALL implement FSM states IDLE, ACCESS, DONE; the reset state is IDLE.
REQ-006 In IDLE with mem_op=1 and fault=0, the block SHALL capture address, store data, load/store and reg_data/reg_address/write_reg, and go to ACCESS.
REQ-007 In IDLE with fault=1, the block SHALL go to DONE with the error latched, and SHALL NOT issue a bus access.
REQ-008 In IDLE with mem_op=0, the block SHALL retire the instruction in the same cycle and stay in IDLE.
REQ-009 In ACCESS, the block SHALL hold dmem_req=1, dmem_we=captured store, dmem_addr=captured address and dmem_wdata=captured store data stable until ack.
REQ-010 In ACCESS with dmem_ack=1, the block SHALL capture dmem_rdata and go to DONE; dmem_req SHALL be 0 from the next cycle.
REQ-011 In ACCESS, an 8-bit wait counter SHALL increment each cycle without ack. On reaching TIMEOUT, the block SHALL go to DONE with the error latched.
REQ-012 dmem_ack SHALL be ignored outside ACCESS.
REQ-013 In DONE, the block SHALL retire the captured instruction and return to IDLE.
REQ-014 stall SHALL be combinational and SHALL equal (IDLE & mem_op) | ACCESS; stall=0 in DONE, so the upstream register advances on the DONE edge.
REQ-015 In DONE, dmem_req SHALL be 0.
REQ-016 Retire SHALL mean the WB outputs register on that edge as follows:
- wb_data = load ? read data : reg_data
- wb_reg_address = reg_address
- wb_write_reg = write_reg & enable & ~error
- wb_enable = 1 (enable when retiring directly from IDLE)
- wb_error = error
REQ-017 On every edge that does not retire, wb_enable, wb_write_reg and wb_error SHALL load 0 (bubble), and wb_data and wb_reg_address SHALL hold their values.
REQ-018 Latency SHALL be 1 cycle for a non-memory instruction. A memory access SHALL take 2 + (cycles until ack), minimum 3 cycles. A faulting instruction SHALL take 2 cycles.
REQ-019 Store data SHALL never reach wb_data; for a store, wb_data = reg_data.
REQ-020 dmem_addr SHALL be the byte address with bits [1:0] forced to 0.

Reset
REQ-021 While reset=0, all state SHALL clear asynchronously to: IDLE, counter 0, dmem_req/dmem_we 0, dmem_addr/dmem_wdata 0, all wb_* outputs 0.
REQ-022 stall SHALL follow REQ-014 with the FSM in IDLE.
REQ-023 Reset asserted during ACCESS SHALL drop dmem_req immediately and abandon the access; no write-back SHALL occur.

Verification
REQ-024 ALU op: enable=1, load=store=0, write_reg=1, reg_data=0x0000_1234, reg_address=5 -> next edge: wb_enable=1, wb_write_reg=1, wb_data=0x1234, wb_reg_address=5, stall=0 throughout.
REQ-025 Load with 2-cycle ack delay: load=1, mem_address=0x100, dmem_rdata=0xDEAD_BEEF -> stall high for 3 cycles; dmem_req high 2 cycles with dmem_addr=0x100 and dmem_we=0; wb_data=0xDEADBEEF one edge after DONE.
REQ-026 Store with immediate ack: store=1, mem_address=0x204, mem_data=0xCAFE_F00D, reg_data=7 -> one ACCESS cycle with dmem_we=1 and dmem_wdata=0xCAFEF00D; wb_write_reg=0; wb_data=7.
REQ-027 Misaligned load at 0x103 -> dmem_req never asserted; wb_error=1 and wb_write_reg=0 after 2 cycles.
REQ-028 No ack, TIMEOUT=4 -> dmem_req high 4 cycles, then wb_error=1; the FSM returns to IDLE.
REQ-029 Reset pulsed mid-ACCESS -> dmem_req=0 and all wb_*=0 immediately; the next instruction proceeds normally.

Source files
------------

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// Memory-access pipeline stage. Non-memory instructions retire to the
// write-back outputs in one cycle. Loads and stores are captured, issued on a
// simple request/acknowledge data bus, and retired once the bus answers, the
// wait times out, or the access is rejected as a fault (misaligned address or
// load and store both set).
//
// Handshake: dmem_req is a registered request. Once raised, dmem_req, dmem_we,
// dmem_addr and dmem_wdata stay constant until the first cycle in which
// dmem_ack is sampled high in ACCESS; that edge completes the transfer, captures
// dmem_rdata and drops dmem_req. dmem_ack is ignored in every other state.
// Upstream is held with the combinational stall output while an instruction is
// being accepted or is waiting on the bus; stall is low in DONE so the upstream
// register advances on the same edge this stage retires.
//
// Parameters:
//   TIMEOUT        maximum number of ACCESS cycles spent waiting for dmem_ack
// Ports:
//   clk, reset     clock (rising edge), asynchronous active-low reset
//   reg_data       ALU result / pass-through data
//   mem_data       store data
//   mem_address    byte address
//   load, store, write_reg, enable, reg_address   MEM-register control
//   stall          freeze upstream pipeline registers
//   dmem_*         data bus request side (req/we/addr/wdata) and response
//                  side (ack/rdata)
//   wb_*           registered write-back outputs
// -----------------------------------------------------------------------------
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] reg_data,
  input  logic [31:0] mem_data,
  input  logic [31:0] mem_address,
  input  logic        load,
  input  logic        store,
  input  logic        write_reg,
  input  logic        enable,
  input  logic [4:0]  reg_address,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_reg_address,
  output logic        wb_write_reg,
  output logic        wb_enable,
  output logic        wb_error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state;
  state_t      state_next;

  // Captured instruction, held from acceptance until retirement.
  logic        cap_load;
  logic [31:0] cap_reg_data;
  logic [4:0]  cap_reg_address;
  logic        cap_write_reg;
  logic        err;
  logic [31:0] rdata_q;
  logic [7:0]  wait_cnt;

  logic        mem_op;
  logic        fault;
  logic [7:0]  wait_next;
  logic        timeout_hit;

  // FSM strobes
  logic        start_access;
  logic        start_fault;
  logic        retire_direct;
  logic        retire_done;
  logic        access_end;

  assign mem_op      = enable & (load | store);
  assign fault       = mem_op & ((mem_address[1:0] != 2'b00) | (load & store));
  assign wait_next   = wait_cnt + 8'd1;
  assign timeout_hit = (wait_next == TIMEOUT_CNT);

  assign stall = ((state == IDLE) & mem_op) | (state == ACCESS);

  always_comb begin
    state_next    = state;
    start_access  = 1'b0;
    start_fault   = 1'b0;
    retire_direct = 1'b0;
    retire_done   = 1'b0;
    access_end    = 1'b0;
    case (state)
      IDLE: begin
        if (fault) begin
          start_fault = 1'b1;
          state_next  = DONE;
        end else if (mem_op) begin
          start_access = 1'b1;
          state_next   = ACCESS;
        end else begin
          // Only a valid instruction retires; an empty slot is a bubble.
          retire_direct = enable;
        end
      end
      ACCESS: begin
        if (dmem_ack || timeout_hit) begin
          access_end = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        retire_done = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      cap_load        <= 1'b0;
      cap_reg_data    <= '0;
      cap_reg_address <= '0;
      cap_write_reg   <= 1'b0;
      err             <= 1'b0;
      rdata_q         <= '0;
      wait_cnt        <= '0;
      dmem_req        <= 1'b0;
      dmem_we         <= 1'b0;
      dmem_addr       <= '0;
      dmem_wdata      <= '0;
      wb_data         <= '0;
      wb_reg_address  <= '0;
      wb_write_reg    <= 1'b0;
      wb_enable       <= 1'b0;
      wb_error        <= 1'b0;
    end else begin
      state <= state_next;

      // Bubble by default; data and address hold unless something retires.
      wb_enable    <= 1'b0;
      wb_write_reg <= 1'b0;
      wb_error     <= 1'b0;

      if (start_access || start_fault) begin
        cap_load        <= load;
        cap_reg_data    <= reg_data;
        cap_reg_address <= reg_address;
        cap_write_reg   <= write_reg;
        err             <= start_fault;
        // Cleared so a faulted or timed-out load writes back a known zero.
        rdata_q         <= '0;
        wait_cnt        <= '0;
      end

      if (start_access) begin
        dmem_req   <= 1'b1;
        dmem_we    <= store;
        dmem_addr  <= {mem_address[31:2], 2'b00};
        dmem_wdata <= mem_data;
      end

      if (state == ACCESS) begin
        if (dmem_ack) begin
          rdata_q <= dmem_rdata;
        end else begin
          wait_cnt <= wait_next;
          if (timeout_hit) begin
            err <= 1'b1;
          end
        end
      end

      if (access_end) begin
        dmem_req <= 1'b0;
        dmem_we  <= 1'b0;
      end

      if (retire_direct) begin
        wb_data        <= reg_data;
        wb_reg_address <= reg_address;
        wb_write_reg   <= write_reg;
        wb_enable      <= 1'b1;
        wb_error       <= 1'b0;
      end

      if (retire_done) begin
        // Store data never reaches write-back: only loads return bus data.
        wb_data        <= cap_load ? rdata_q : cap_reg_data;
        wb_reg_address <= cap_reg_address;
        wb_write_reg   <= cap_write_reg & ~err;
        wb_enable      <= 1'b1;
        wb_error       <= err;
      end
    end
  end

endmodule
